// File: rtl/sd_pkg.sv
// Shared types and constants for the SD command-line deserializer.
package sd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_SHIFT      = 2'd2,
        ST_DONE       = 2'd3
    } state_e;

    localparam logic [6:0] CRC7_POLY = 7'h09;
    localparam logic       LINE_IDLE = 1'b1;

    // Requested length 0 or wider than the register means "use the full width".
    function automatic logic [7:0] clamp_fs(input logic [7:0] req, input logic [7:0] max_fs);
        return (req == 8'd0 || req > max_fs) ? max_fs : req;
    endfunction

endpackage

// File: rtl/sd_cmd_deserializer_if.sv
// Capture request / frame result bundle between a controller and sd_cmd_deserializer.
interface sd_cmd_deserializer_if #(parameter int MAX_BITS = 136);
    logic                enable;
    logic                in;
    logic [7:0]          framesize;
    logic [MAX_BITS-1:0] out;
    logic                complete;
    logic                timeout;
    logic                busy;
    logic                crc_ok;

    modport master (output enable, in, framesize,
                    input  out, complete, timeout, busy, crc_ok);
    modport slave  (input  enable, in, framesize,
                    output out, complete, timeout, busy, crc_ok);
endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one message bit per enabled cycle, clear to zero.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);
    logic [6:0] crc_q, crc_d;
    logic       fb;

    always_comb begin
        crc_d = crc_q;
        fb    = bit_in ^ crc_q[6];
        if (clr)
            crc_d = '0;
        else if (en)
            crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc_q <= '0;
        else        crc_q <= crc_d;
    end

    assign crc = crc_q;
endmodule

// File: rtl/sd_cmd_deserializer.sv
// Serial-to-parallel capture of one SD command/response frame per enable request.
// Optional CRC7 checking is built when SD_CMD_CRC7_EN is defined; otherwise crc_ok is tied high.
module sd_cmd_deserializer
    import sd_pkg::*;
#(
    parameter int MAX_BITS       = 136,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    sd_cmd_deserializer_if.slave  bus
);
    localparam logic [7:0]  MAX_FS    = 8'(MAX_BITS);
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [7:0]          fs_q, fs_d, cnt_q, cnt_d;
    logic [15:0]         wait_q, wait_d;
    logic [MAX_BITS-1:0] sr_q, sr_d, out_q, out_d;
    logic                complete_q, complete_d, timeout_q, timeout_d, crc_ok_q, crc_ok_d;

`ifdef SD_CMD_CRC7_EN
    logic [6:0] crc;
    logic       crc_clr, crc_en;

    // The CRC covers every frame bit except the trailing CRC byte, start bit included.
    assign crc_clr = (state_q == ST_IDLE);
    assign crc_en  = bus.enable && (({1'b0, cnt_q} + 9'd8) < {1'b0, fs_q}) &&
                     (state_q == ST_SHIFT ||
                      (state_q == ST_WAIT_START && bus.in != LINE_IDLE));

    sd_crc7 u_crc7 (
        .clk   (clk),
        .rst_n (reset),
        .clr   (crc_clr),
        .en    (crc_en),
        .bit_in(bus.in),
        .crc   (crc)
    );
`endif

    always_comb begin
        state_d    = state_q;
        fs_d       = fs_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        sr_d       = sr_q;
        out_d      = out_q;
        complete_d = 1'b0;
        timeout_d  = 1'b0;
`ifdef SD_CMD_CRC7_EN
        crc_ok_d   = crc_ok_q;
`else
        crc_ok_d   = 1'b1;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    fs_d    = clamp_fs(bus.framesize, MAX_FS);
                    cnt_d   = '0;
                    wait_d  = '0;
                    state_d = ST_WAIT_START;
                end
            end
            ST_WAIT_START: begin
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                end else if (bus.in != LINE_IDLE) begin
                    sr_d    = MAX_BITS'(bus.in);
                    cnt_d   = 8'd1;
                    state_d = ST_SHIFT;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            ST_SHIFT: begin
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == fs_q) begin
                    state_d = ST_DONE;
                end else begin
                    sr_d  = {sr_q[MAX_BITS-2:0], bus.in};
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                // Bits above the frame length are stale from older frames.
                for (int i = 0; i < MAX_BITS; i++)
                    out_d[i] = (8'(i) < fs_q) ? sr_q[i] : 1'b0;
                complete_d = 1'b1;
`ifdef SD_CMD_CRC7_EN
                crc_ok_d   = (crc == out_d[7:1]);
`endif
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            fs_q       <= '0;
            cnt_q      <= '0;
            wait_q     <= '0;
            sr_q       <= '0;
            out_q      <= '0;
            complete_q <= 1'b0;
            timeout_q  <= 1'b0;
            crc_ok_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fs_q       <= fs_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            sr_q       <= sr_d;
            out_q      <= out_d;
            complete_q <= complete_d;
            timeout_q  <= timeout_d;
            crc_ok_q   <= crc_ok_d;
        end
    end

    assign bus.out      = out_q;
    assign bus.complete = complete_q;
    assign bus.timeout  = timeout_q;
    assign bus.crc_ok   = crc_ok_q;
    assign bus.busy     = (state_q == ST_WAIT_START) || (state_q == ST_SHIFT);
endmodule

// File: tb/tb_sd_cmd_deserializer.sv
// Directed plus randomized frame captures checked against a frame-level reference model.
module tb_sd_cmd_deserializer;
`ifdef SD_CMD_CRC7_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif
    localparam int MB = 136;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    sd_cmd_deserializer_if #(.MAX_BITS(MB)) bus ();
    sd_cmd_deserializer #(.MAX_BITS(MB), .TIMEOUT_CYCLES(64)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (reset === 1'b1) chk("excl", {255'd0, bus.complete & bus.timeout}, 256'd0);

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Expected register contents: the frame's last fs bits, right-aligned, upper bits zero.
    function automatic logic [255:0] exp_out(input logic [255:0] frame, input int fs);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < fs; i++) r[i] = frame[i];
        return r;
    endfunction

    // Remainder of M(x)*x^7 divided by x^7+x^3+1, M = frame bits above the CRC byte.
    function automatic logic [6:0] crc_rem(input logic [255:0] frame, input int fs);
        logic [262:0] m;
        m = '0;
        for (int i = 0; i < fs - 8; i++) m[i + 7] = frame[i + 8];
        for (int i = fs - 2; i >= 7; i--)
            if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
        return m[6:0];
    endfunction

    function automatic logic exp_crc(input logic [255:0] frame, input int fs);
        if (!CRC_EN) return 1'b1;
        return crc_rem(frame, fs) == frame[7:1];
    endfunction

    // Drives one whole frame and checks latency, out and crc_ok; leaves enable low.
    task automatic send_frame(input string tag, input logic [255:0] frame, input int fs,
                              input logic [7:0] fsreq, input int idle, input bit scramble);
        bus.framesize = fsreq;
        bus.enable    = 1'b1;
        bus.in        = 1'b1;
        tick();
        chk({tag, ".busy"}, {255'd0, bus.busy}, 256'd1);
        repeat (idle) tick();
        for (int i = fs - 1; i >= 0; i--) begin
            bus.in = frame[i];
            if (scramble) bus.framesize = 8'($urandom);
            tick();
        end
        bus.in = 1'b1;
        tick();
        chk({tag, ".lat"}, {255'd0, bus.complete}, 256'd0);
        tick();
        chk({tag, ".cmp"}, {255'd0, bus.complete}, 256'd1);
        chk({tag, ".out"}, 256'(bus.out), exp_out(frame, fs));
        chk({tag, ".crc"}, {255'd0, bus.crc_ok}, {255'd0, exp_crc(frame, fs)});
        bus.enable = 1'b0;
        tick();
        chk({tag, ".pulse"}, {255'd0, bus.complete}, 256'd0);
        chk({tag, ".hold"}, 256'(bus.out), exp_out(frame, fs));
    endtask

    initial begin
        logic [255:0] f, last_f;
        int           last_fs, k, fs;
        logic [7:0]   fsreq;

        reset = 1'b0;
        bus.enable = 1'b0;
        bus.in = 1'b1;
        bus.framesize = 8'd0;
        #3;
        chk("rst.out", 256'(bus.out), 256'd0);
        chk("rst.cmp", {255'd0, bus.complete}, 256'd0);
        chk("rst.to", {255'd0, bus.timeout}, 256'd0);
        chk("rst.busy", {255'd0, bus.busy}, 256'd0);
        chk("rst.crc", {255'd0, bus.crc_ok}, 256'd0);
        #19 reset = 1'b1;
        tick();
        chk("rel.crc", {255'd0, bus.crc_ok}, {255'd0, !CRC_EN});
        chk("rel.busy", {255'd0, bus.busy}, 256'd0);

        f = 256'h400000000095;
        send_frame("cmd0", f, 48, 8'd48, 5, 1'b0);
        f = 256'h400000000097;
        send_frame("badcrc", f, 48, 8'd48, 5, 1'b0);
        last_f = f; last_fs = 48;

        // Line held high: timeout after exactly 64 WAIT_START cycles.
        bus.enable = 1'b1;
        tick();
        k = 0;
        while (bus.busy && k < 200) begin
            chk("to.nocmp", {255'd0, bus.complete}, 256'd0);
            k++;
            tick();
        end
        bus.enable = 1'b0;
        chk("to.cycles", 256'(k), 256'd64);
        chk("to.pulse", {255'd0, bus.timeout}, 256'd1);
        tick();
        chk("to.end", {255'd0, bus.timeout}, 256'd0);
        chk("to.hold", 256'(bus.out), exp_out(last_f, last_fs));
        chk("to.crc", {255'd0, bus.crc_ok}, {255'd0, exp_crc(last_f, last_fs)});

        f = '0;
        for (int i = 134; i >= 0; i--) f[i] = ((134 - i) % 2 == 0);
        send_frame("alt136", f, 136, 8'd136, 2, 1'b0);
        last_f = f; last_fs = 136;

        // framesize 200 clamps to 136; abort after 20 bits leaves the old frame.
        bus.framesize = 8'd200;
        bus.enable = 1'b1;
        tick();
        f = rand256();
        f[135] = 1'b0;
        for (int i = 135; i > 115; i--) begin
            bus.in = f[i];
            tick();
        end
        bus.enable = 1'b0;
        bus.in = 1'b1;
        tick();
        chk("abort.busy", {255'd0, bus.busy}, 256'd0);
        repeat (4) begin
            tick();
            chk("abort.cmp", {255'd0, bus.complete | bus.timeout}, 256'd0);
        end
        chk("abort.out", 256'(bus.out), exp_out(last_f, last_fs));
        chk("abort.crc", {255'd0, bus.crc_ok}, {255'd0, exp_crc(last_f, last_fs)});
        send_frame("clamp200", f, 136, 8'd200, 1, 1'b0);

        // Asynchronous reset part way through a 48-bit frame.
        bus.framesize = 8'd48;
        bus.enable = 1'b1;
        tick();
        f = rand256();
        f[47] = 1'b0;
        for (int i = 47; i > 17; i--) begin
            bus.in = f[i];
            tick();
        end
        #2 reset = 1'b0;
        #1;
        chk("mid.out", 256'(bus.out), 256'd0);
        chk("mid.busy", {255'd0, bus.busy}, 256'd0);
        chk("mid.crc", {255'd0, bus.crc_ok}, 256'd0);
        chk("mid.cmp", {255'd0, bus.complete | bus.timeout}, 256'd0);
        bus.enable = 1'b0;
        bus.in = 1'b1;
        tick();
        #3 reset = 1'b1;
        tick();
        f[7:1] = crc_rem(f, 48);
        send_frame("post", f, 48, 8'd48, 3, 1'b0);

        for (int n = 0; n < 12; n++) begin
            fs = $urandom_range(8, 135);
            if ($urandom_range(0, 3) == 0) fs = 136;
            fsreq = 8'(fs);
            if (fs == 136) fsreq = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'(200 + $urandom_range(0, 55));
            f = rand256();
            f[fs - 1] = 1'b0;
            if ($urandom_range(0, 1) == 0) f[7:1] = crc_rem(f, fs);
            send_frame($sformatf("rnd%0d", n), f, fs, fsreq, $urandom_range(0, 10), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
